// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and widths for the stopwatch control slice.
// The optional auto-stop behaviour in stopwatch_ctrl is enabled by STOPWATCH_AUTOSTOP_EN.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam int DISP_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAP  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  // The counter advances in both running states; the lap view does not pause timing.
  function automatic logic isCounting(input state_t s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, debounce counter and press-edge pulse for one raw button.
// A press yields one pulse 2+DEB_CYCLES cycles after the raw edge; releases yield nothing.
module btn_debounce #(
  parameter int DEB_CYCLES = 2
) (
  input  logic clkin,
  input  logic clrn,
  input  logic i_btn,
  output logic o_pulse
);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic [3:0] r_cnt;
  logic       r_pulse;
  logic       w_differs;
  logic       w_flip;

  // Bring the asynchronous button into the clock domain; reset treats it as released.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // The level flips once DEB_CYCLES consecutive synchronised samples disagree with it.
  always_comb begin
    w_differs = (r_sync2 != r_level);
    w_flip    = w_differs && (r_cnt == 4'(DEB_CYCLES - 1));
  end

  // Count disagreeing samples, commit the new level, and pulse only on a rising commit.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      r_level <= 1'b0;
      r_cnt   <= 4'd0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= w_flip && r_sync2;
      if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= 4'd0;
      end else if (w_differs) begin
        r_cnt   <= r_cnt + 4'd1;
      end else begin
        r_cnt   <= 4'd0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button-driven control FSM, lap snapshot and display mux for the BCD stopwatch.
// Define STOPWATCH_AUTOSTOP_EN to stop the watch when the counter carries out while running.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = 2,
  parameter int DIGIT_W    = 4
) (
  input  logic                 clkin,
  input  logic                 clrn,
  input  logic                 btn_ss,
  input  logic                 btn_lr,
  input  logic [DIGIT_W-1:0]   cnt_dsec,
  input  logic [DIGIT_W-1:0]   cnt_sec,
  input  logic [DIGIT_W-1:0]   cnt_secd,
  input  logic [DIGIT_W-1:0]   cnt_secm,
  input  logic                 cnt_cn,
  output logic                 cnt_en,
  output logic                 cnt_clr_n,
  output logic [4*DIGIT_W-1:0] disp,
  output logic [1:0]           state_o
);

  state_t               r_state;
  state_t               w_next;
  logic [4*DIGIT_W-1:0] r_lap;
  logic [4*DIGIT_W-1:0] w_live;
  logic                 r_clrN;
  logic                 w_ssPulse;
  logic                 w_lrPulse;
  logic                 w_capture;
  logic                 w_clear;
  logic                 w_autostop;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debSs (
    .clkin   (clkin),
    .clrn    (clrn),
    .i_btn   (btn_ss),
    .o_pulse (w_ssPulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debLr (
    .clkin   (clkin),
    .clrn    (clrn),
    .i_btn   (btn_lr),
    .o_pulse (w_lrPulse)
  );

  assign w_live = {cnt_secm, cnt_secd, cnt_sec, cnt_dsec};

  // Next state: auto-stop beats buttons, start/stop beats lap/reset when both pulse together.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_clear   = 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
    w_autostop = cnt_cn && isCounting(r_state);
`else
    // Carry is tied off here so the counter wraps freely while running.
    w_autostop = cnt_cn & 1'b0;
`endif
    if (w_autostop) begin
      w_next = ST_STOP;
    end else if (w_ssPulse) begin
      case (r_state)
        ST_IDLE: w_next = ST_RUN;
        ST_RUN:  w_next = ST_STOP;
        ST_LAP:  w_next = ST_STOP;
        ST_STOP: w_next = ST_RUN;
        default: w_next = ST_IDLE;
      endcase
    end else if (w_lrPulse) begin
      case (r_state)
        ST_RUN: begin
          w_next    = ST_LAP;
          w_capture = 1'b1;
        end
        ST_LAP:  w_next = ST_RUN;
        ST_STOP: begin
          w_next  = ST_IDLE;
          w_clear = 1'b1;
        end
        default: w_next = r_state;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Freeze the live digits on entry to LAP and hold them while the counter keeps running.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      r_lap <= '0;
    end else if (w_capture) begin
      r_lap <= w_live;
    end
  end

  // One-cycle low clear pulse to the counter following the STOP-to-IDLE reset.
  always_ff @(posedge clkin or negedge clrn) begin
    if (!clrn) begin
      r_clrN <= 1'b1;
    end else begin
      r_clrN <= ~w_clear;
    end
  end

  assign cnt_en    = isCounting(r_state);
  assign cnt_clr_n = r_clrN;
  assign disp      = (r_state == ST_LAP) ? r_lap : w_live;
  assign state_o   = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: randomized scoreboard bench for stopwatch_ctrl against a behavioural model.
// Honours STOPWATCH_AUTOSTOP_EN the same way the design does.
module tb_stopwatch_ctrl;

  localparam int DEB = 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAP  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;
`ifdef STOPWATCH_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic        clkin = 1'b0;
  logic        clrn = 1'b0;
  logic        btn_ss = 1'b0;
  logic        btn_lr = 1'b0;
  logic [3:0]  cnt_dsec = 4'd0;
  logic [3:0]  cnt_sec = 4'd0;
  logic [3:0]  cnt_secd = 4'd0;
  logic [3:0]  cnt_secm = 4'd0;
  logic        cnt_cn = 1'b0;
  logic        cnt_en;
  logic        cnt_clr_n;
  logic [15:0] disp;
  logic [1:0]  state_o;

  typedef struct packed {
    logic [1:0]  st;
    logic        en;
    logic        clrN;
    logic [15:0] disp;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  bit   running = 1'b0;

  // Behavioural model: raw-sample history per button plus abstract watch state.
  logic        rawSs[$];
  logic        rawLr[$];
  logic        mLvlSs, mLvlLr;
  logic        mPendSs, mPendLr;
  logic [1:0]  mState;
  logic [15:0] mLap;
  logic        mClrN;

  logic ssDrive = 1'b0;
  logic lrDrive = 1'b0;
  logic rstnDrive = 1'b0;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .DIGIT_W(4)) dut (
    .clkin     (clkin),
    .clrn      (clrn),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .cnt_dsec  (cnt_dsec),
    .cnt_sec   (cnt_sec),
    .cnt_secd  (cnt_secd),
    .cnt_secm  (cnt_secm),
    .cnt_cn    (cnt_cn),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .disp      (disp),
    .state_o   (state_o)
  );

  always #5 clkin = ~clkin;

  task automatic modelReset();
    mState  = S_IDLE;
    mLap    = 16'h0000;
    mClrN   = 1'b1;
    mPendSs = 1'b0;
    mPendLr = 1'b0;
    mLvlSs  = 1'b0;
    mLvlLr  = 1'b0;
    rawSs.delete();
    rawLr.delete();
    for (int i = 0; i < DEB + 2; i++) begin
      rawSs.push_back(1'b0);
      rawLr.push_back(1'b0);
    end
  endtask

  // The oldest DEB samples are those that have cleared the two synchroniser stages.
  function automatic void debStep(input logic q[$], inout logic level, output logic pulse);
    logic same;
    same  = 1'b1;
    pulse = 1'b0;
    for (int i = 1; i < DEB; i++) if (q[i] != q[0]) same = 1'b0;
    if (same && (q[0] != level)) begin
      level = q[0];
      pulse = level;
    end
  endfunction

  task automatic modelEdge();
    logic newSs, newLr;
    if (!clrn) begin
      modelReset();
      return;
    end
    mClrN = 1'b1;
    if (AUTOSTOP && cnt_cn && (mState == S_RUN || mState == S_LAP)) begin
      mState = S_STOP;
    end else if (mPendSs) begin
      mState = (mState == S_RUN || mState == S_LAP) ? S_STOP : S_RUN;
    end else if (mPendLr) begin
      if (mState == S_RUN) begin
        mLap   = {cnt_secm, cnt_secd, cnt_sec, cnt_dsec};
        mState = S_LAP;
      end else if (mState == S_LAP) begin
        mState = S_RUN;
      end else if (mState == S_STOP) begin
        mState = S_IDLE;
        mClrN  = 1'b0;
      end
    end
    rawSs.push_back(btn_ss);
    rawLr.push_back(btn_lr);
    void'(rawSs.pop_front());
    void'(rawLr.pop_front());
    debStep(rawSs, mLvlSs, newSs);
    debStep(rawLr, mLvlLr, newLr);
    mPendSs = newSs;
    mPendLr = newLr;
  endtask

  // One clock: advance the model on the edge, then drive fresh inputs and predict outputs.
  task automatic runCycle();
    exp_t e;
    @(posedge clkin);
    modelEdge();
    #2;
    btn_ss   = ssDrive;
    btn_lr   = lrDrive;
    clrn     = rstnDrive;
    cnt_dsec = 4'($urandom_range(0, 15));
    cnt_sec  = 4'($urandom_range(0, 15));
    cnt_secd = 4'($urandom_range(0, 15));
    cnt_secm = 4'($urandom_range(0, 15));
    cnt_cn   = ($urandom_range(0, 15) == 0);
    if (!clrn) modelReset();
    e.st   = mState;
    e.en   = (mState == S_RUN || mState == S_LAP);
    e.clrN = mClrN;
    e.disp = (mState == S_LAP) ? mLap : {cnt_secm, cnt_secd, cnt_sec, cnt_dsec};
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic ss, input logic lr, input logic rstn, input int cycles);
    ssDrive   = ss;
    lrDrive   = lr;
    rstnDrive = rstn;
    for (int i = 0; i < cycles; i++) runCycle();
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output cycle is compared against the oldest prediction.
  always @(negedge clkin) begin
    exp_t e;
    if (running) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL queue_empty: got 0 entries expected at least 1 at %0t", $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("state", {14'd0, state_o}, {14'd0, e.st});
        checkOutput("cnt_en", {15'd0, cnt_en}, {15'd0, e.en});
        checkOutput("cnt_clr_n", {15'd0, cnt_clr_n}, {15'd0, e.clrN});
        checkOutput("disp", disp, e.disp);
      end
    end
  end

  initial begin
    int kind;
    modelReset();
    running = 1'b1;
    // Reset, then a held start press, a glitch, lap in and out, both together, clear.
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 5);
    applyStimulus(1'b0, 1'b0, 1'b1, 6);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 8);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 6);
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 6);
    applyStimulus(1'b0, 1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 6);
    // Start, then reset mid-run with a press still in flight.
    applyStimulus(1'b1, 1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    // Random mix of presses, glitches, simultaneous presses, gaps and resets.
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 19);
      if (kind < 6)       applyStimulus(1'b1, 1'b0, 1'b1, $urandom_range(1, 6));
      else if (kind < 12) applyStimulus(1'b0, 1'b1, 1'b1, $urandom_range(1, 6));
      else if (kind < 14) applyStimulus(1'b1, 1'b1, 1'b1, $urandom_range(1, 5));
      else if (kind < 19) applyStimulus(1'b0, 1'b0, 1'b1, $urandom_range(1, 8));
      else                applyStimulus(1'b0, 1'b0, 1'b0, $urandom_range(1, 2));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4);
    @(negedge clkin);
    #1;
    running = 1'b0;
    checkOutput("leftover", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
